// File: rtl/parity_serial_tx.sv
// parity_serial_tx
//   Takes a data word plus its upstream parity bit over valid/ready and sends
//   it as an asynchronous frame: start(0), data LSB first, parity, stop(1)s.
//   Parity is also recomputed here. A disagreement with parity_in raises
//   parity_err, but parity_in is still sent unchanged.
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   data_in      : word to transmit (DATA_WIDTH)
//   parity_in    : generator parity for data_in
//   data_valid   : data_in/parity_in valid
//   data_ready   : IDLE and not in reset (combinational)
//   tx_out       : serial line, idle high
//   busy         : frame in progress
//   frame_done   : 1-cycle pulse when the last stop bit completes
//   parity_err   : 1-cycle pulse the cycle after an acceptance with bad parity
module parity_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_TYPE  = 0,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  parity_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = (STOP_BITS > 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_q;
  logic                  local_par;
  logic                  bit_end;
  logic [DATA_WIDTH-1:0] shreg_nxt;

  assign local_par  = (PARITY_TYPE != 0) ? ~(^data_in) : (^data_in);
  assign bit_end    = (cnt == CNT_MAX);
  assign shreg_nxt  = shreg >> 1;
  assign data_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_q      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      // One counter paces every bit slot; it wraps at each bit boundary.
      if (state != IDLE) cnt <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (data_valid) begin
          shreg      <= data_in;
          par_q      <= parity_in;
          parity_err <= (parity_in != local_par);
          state      <= START;
          tx_out     <= 1'b0;
          busy       <= 1'b1;
          cnt        <= '0;
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= '0;
          tx_out  <= shreg[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == BIT_LAST) begin
            state  <= PARITY;
            tx_out <= par_q;     // sent as supplied, even if wrong
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= shreg_nxt;
            tx_out  <= shreg_nxt[0];
          end
        end
        PARITY: if (bit_end) begin
          state    <= STOP;
          stop_idx <= 1'b0;
          tx_out   <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            stop_idx <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench: dut_a is even parity with 1 stop bit, dut_b is odd parity
// with 2 stop bits. Both use 4 clocks per bit. Expected frames are written
// out by hand, bit 0 = first bit on the line.
module tb_parity_serial_tx;
  localparam int CPB = 4;

  logic       clk, rst;
  logic [7:0] da, db;
  logic       pa, pb, va, vb;
  logic       ra, rb, txa, txb, ba, bb, fda, fdb, pea, peb;

  int   checks = 0;
  int   failures = 0;
  logic sel = 1'b0;
  logic r_s, tx_s, b_s, fd_s, pe_s;

  parity_serial_tx #(.DATA_WIDTH(8), .PARITY_TYPE(0), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(da), .parity_in(pa), .data_valid(va),
    .data_ready(ra), .tx_out(txa), .busy(ba), .frame_done(fda), .parity_err(pea));

  parity_serial_tx #(.DATA_WIDTH(8), .PARITY_TYPE(1), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(db), .parity_in(pb), .data_valid(vb),
    .data_ready(rb), .tx_out(txb), .busy(bb), .frame_done(fdb), .parity_err(peb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    r_s  = sel ? rb  : ra;
    tx_s = sel ? txb : txa;
    b_s  = sel ? bb  : ba;
    fd_s = sel ? fdb : fda;
    pe_s = sel ? peb : pea;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic p, input logic v);
    if (sel) begin db = d; pb = p; vb = v; end
    else     begin da = d; pa = p; va = v; end
  endtask

  // Present a word and return just after the accepting edge.
  task automatic accept(input logic [7:0] d, input logic p);
    int n = 0;
    drive(d, p, 1'b1);
    while (!r_s && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", r_s, 1'b1);
    @(posedge clk);
  endtask

  // Watch a frame whose acceptance edge has just passed, then check the
  // frame_done/idle cycle. keep leaves data_valid high with the next word.
  task automatic watch(input string tag, input logic [15:0] exp, input int nbits,
                       input logic exp_pe, input bit keep, input logic [7:0] nxt,
                       input bit holdoff);
    int busy_n = 0, rdy_n = 0, fd_n = 0;
    for (int j = 0; j < nbits * CPB; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk({tag, "_perr"}, pe_s, exp_pe);
        if (keep) drive(nxt, 1'b0, 1'b1);
        else      drive(8'h00, 1'b0, 1'b0);
      end
      if (j == 1) chk({tag, "_perr_clr"}, pe_s, 1'b0);
      if (holdoff && j == 10) drive(8'hFF, 1'b1, 1'b1);
      if (holdoff && j == 11) drive(8'h00, 1'b0, 1'b0);
      chk($sformatf("%s_tx%0d", tag, j), tx_s, exp[j / CPB]);
      busy_n += int'(b_s);
      rdy_n  += int'(r_s);
      fd_n   += int'(fd_s);
    end
    chk({tag, "_busy_cycles"}, busy_n, nbits * CPB);
    chk({tag, "_ready_low"}, rdy_n, 0);
    chk({tag, "_no_early_done"}, fd_n, 0);
    @(negedge clk);
    chk({tag, "_done"}, fd_s, 1'b1);
    chk({tag, "_idle_tx"}, tx_s, 1'b1);
    chk({tag, "_idle_busy"}, b_s, 1'b0);
    chk({tag, "_idle_ready"}, r_s, 1'b1);
    if (!keep) begin
      @(negedge clk);
      chk({tag, "_done_clr"}, fd_s, 1'b0);
      chk({tag, "_stay_idle"}, tx_s, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    da = 8'h00; pa = 1'b0; va = 1'b1;   // valid during reset must be ignored
    db = 8'h00; pb = 1'b0; vb = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", txa, 1'b1);
    chk("rst_tx_b", txb, 1'b1);
    chk("rst_busy", ba, 1'b0);
    chk("rst_done", fda, 1'b0);
    chk("rst_perr", pea, 1'b0);
    chk("rst_ready", ra, 1'b0);
    va = 1'b0; vb = 1'b0;
    rst = 1'b0;
    #1 chk("ready_after_rst", ra, 1'b1);
    @(negedge clk);

    // Even frame: 0xA5, parity 0
    sel = 1'b0;
    accept(8'hA5, 1'b0);
    watch("even", 16'b10101001010, 11, 1'b0, 1'b0, 8'h00, 1'b0);

    // Odd frame, 2 stop bits: 0x07, parity 0
    sel = 1'b1;
    accept(8'h07, 1'b0);
    watch("odd", 16'b110000001110, 12, 1'b0, 1'b0, 8'h00, 1'b0);
    sel = 1'b0;

    // Mismatch: 0x01 with parity 0 under even parity
    accept(8'h01, 1'b0);
    watch("mism", 16'b10000000010, 11, 1'b1, 1'b0, 8'h00, 1'b0);

    // Back-to-back 0x3C then 0xC3 with valid held
    accept(8'h3C, 1'b0);
    watch("b2b1", 16'b10001111000, 11, 1'b0, 1'b1, 8'hC3, 1'b0);
    watch("b2b2", 16'b10110000110, 11, 1'b0, 1'b0, 8'h00, 1'b0);

    // Hold-off: valid pulsed with 0xFF mid-frame of 0x3C
    accept(8'h3C, 1'b0);
    watch("hold", 16'b10001111000, 11, 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset during data bit 3 (line slot 4 = cycles 16..19)
    accept(8'hA5, 1'b0);
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j == 0) drive(8'h00, 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_tx", txa, 1'b1);
    chk("mrst_busy", ba, 1'b0);
    chk("mrst_done", fda, 1'b0);
    chk("mrst_ready", ra, 1'b0);
    rst = 1'b0;
    #1 chk("mrst_ready_after", ra, 1'b1);
    accept(8'h3C, 1'b0);
    watch("post_rst", 16'b10001111000, 11, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Downstream consumer of the parity generator. Accepts a data word plus its generated parity bit over a valid/ready handshake and serialises it as an asynchronous frame: start bit, data bits LSB first, parity bit, stop bit(s). It recomputes parity locally and flags any disagreement with the supplied bit, as a cross-check on the generator stage.

Parameters:
DATA_WIDTH, 8, data bits per frame (>=1)
PARITY_TYPE, 0, 0 = even, 1 = odd; must match the upstream generator setting
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
data_in  input  DATA_WIDTH  word to transmit
parity_in  input  1  parity bit from the generator for data_in
data_valid  input  1  data_in/parity_in valid
data_ready  output  1  block can accept a word
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse when the last stop bit completes
parity_err  output  1  one-cycle pulse when parity_in disagrees with the local parity

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. Internal signals: cycle counter 0..CLKS_PER_BIT-1, bit index 0..DATA_WIDTH-1, stop index 0..STOP_BITS-1, shift register, parity register.
- Reset (rst sampled high): state = IDLE, tx_out = 1, busy = 0, frame_done = 0, parity_err = 0, counters = 0.
- data_ready = (state == IDLE) && !rst. This is the only combinational output.
- Acceptance: data_valid && data_ready at a clock edge. On that edge:
  - capture data_in and parity_in;
  - move to START with tx_out = 0 and busy = 1.
  - data_in is ignored when it is not accepted.
- Local parity = ^data_in for even, ~^data_in for odd. If parity_in != local parity, parity_err = 1 for exactly the cycle after acceptance.
- The frame still transmits parity_in unchanged, so downstream checkers see the fault.
- Each bit holds tx_out for exactly CLKS_PER_BIT cycles. The counter wraps CLKS_PER_BIT-1 -> 0 at each bit boundary.
- START -> DATA after 1 bit time. DATA shifts out bit 0 first.
- DATA -> PARITY after DATA_WIDTH bit times; tx_out = captured parity_in.
- PARITY -> STOP after 1 bit time; tx_out = 1.
- STOP -> IDLE after STOP_BITS bit times.
- Timing from an acceptance at edge k, with F = (DATA_WIDTH + 2 + STOP_BITS) * CLKS_PER_BIT:
  - start bit occupies cycles k+1 .. k+CLKS_PER_BIT;
  - at edge k+F the state is IDLE, busy = 0, and frame_done = 1 for that single cycle;
  - data_ready is high from that cycle.
- Back-to-back: with data_valid held high, the next acceptance happens at edge k+F+1. That gives exactly one idle-high cycle between frames, which is the minimum gap. No acceptance is possible while busy.
- Reset mid-frame: on the edge rst is sampled, tx_out = 1 and the state returns to IDLE. The partial frame is dropped and no frame_done or parity_err is produced. Acceptance is possible on the first edge after rst falls.
- data_valid with rst high: ignored.

Test Plan:
- Even-parity frame. Setup: DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, PARITY_TYPE=0. Stimulus: accept 0xA5 with parity_in=0. Required: tx_out sequence 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles (44 cycles); frame_done pulse at edge k+44; parity_err never asserts.
- Odd-parity frame. Setup: PARITY_TYPE=1, 2 stop bits. Stimulus: 0x07 with parity_in=0. Required: bits 0,1,1,1,0,0,0,0,0,0,1,1; busy high for 48 cycles; no parity_err.
- Parity mismatch. Setup: even parity. Stimulus: 0x01 with parity_in=0. Required: parity_err = 1 for exactly one cycle after acceptance; parity slot on the line = 0; frame otherwise normal.
- Back-to-back. Stimulus: data_valid held high with 0x3C then 0xC3. Required: exactly one tx_out=1 idle cycle between the last stop bit and the second start bit; data_ready low throughout both frames.
- Reset mid-frame. Stimulus: rst pulsed during data bit 3. Required: tx_out = 1 from the next edge; no frame_done; a new word accepted right after reset transmits a correct full frame.
- Handshake hold-off. Stimulus: data_valid pulsed while busy. Required: word not captured; transmitted frame unchanged.
